// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU unit bank between two requesters.
// Define ALU_SCHED_B2B_EN to accept a new command on the response handshake edge.
module alu_op_scheduler #(
    parameter int WIDTH = 4,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       unit_en,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic [WIDTH-1:0] unit_y,
    input  logic             unit_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cout,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic grant_id;
    logic issue_open;
    logic accept;

    // On contention the requester that did not win last time goes first.
    assign grant_id = (req0_valid & req1_valid) ? ~last_grant_q
                                                : (req1_valid & ~req0_valid);

`ifdef ALU_SCHED_B2B_EN
    assign issue_open = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
`else
    assign issue_open = (state_q == IDLE);
`endif

    assign req0_ready = issue_open & ~rst & req0_valid & ~grant_id;
    assign req1_ready = issue_open & ~rst & req1_valid & grant_id;
    assign accept     = req0_ready | req1_ready;

    assign unit_a   = a_q;
    assign unit_b   = b_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_y    = rsp_y_q;
    assign rsp_cout = rsp_cout_q;
    assign rsp_zero = rsp_zero_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_zero_d   = rsp_zero_q;
        unit_en      = 4'b0000;
        rsp_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            EXEC: begin
                unit_en    = 4'b0001 << op_q;
                rsp_y_d    = unit_y;
                rsp_cout_d = unit_cout;
                rsp_zero_d = (unit_y == '0);
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A handshake overrides the RESP->IDLE step when back-to-back is on.
        if (accept) begin
            op_d         = grant_id ? req1_op : req0_op;
            a_d          = grant_id ? req1_a : req0_a;
            b_d          = grant_id ? req1_b : req0_b;
            id_d         = grant_id;
            last_grant_d = grant_id;
            state_d      = EXEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

endmodule
